// File: rtl/fp_wire_pkg.sv
// Shared types for the FPU result scoreboard: expected-entry layout, canonical NaNs
// and the NaN-relaxed result difference.
package fp_wire;

  localparam logic [31:0] CanonNanS = 32'h7FC0_0000;
  localparam logic [63:0] CanonNanD = 64'h7FF8_0000_0000_0000;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic [1:0]  fmt;
    logic        nanrelax;
    logic        last;
  } fp_sb_entry_type;

  localparam int unsigned EntryW = $bits(fp_sb_entry_type);

  // A canonical-NaN DUT result only has to match the exponent and quiet bit.
  function automatic logic [63:0] fp_result_diff(fp_sb_entry_type e, logic [63:0] dut);
    if (e.fmt == 2'd0 && e.nanrelax && dut[31:0] == CanonNanS) begin
      return {32'h0, 1'b0, dut[30:22] ^ e.result[30:22], 22'h0};
    end else if (e.fmt != 2'd0 && e.nanrelax && dut == CanonNanD) begin
      return {1'b0, dut[62:51] ^ e.result[62:51], 51'h0};
    end else begin
      return dut ^ e.result;
    end
  endfunction

endpackage

// File: rtl/fp_sb_fifo.sv
// Expected-entry FIFO: storage plus wrap pointers with an extra MSB for full/empty.
module fp_sb_fifo
  import fp_wire::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [EntryW-1:0]        wdata_i,
  output logic [EntryW-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/fp_scoreboard.sv
// FPU result scoreboard: queues expected results, compares each FPU completion against
// the oldest entry and keeps registered diffs, counters and sticky status.
module fp_scoreboard
  import fp_wire::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [63:0]            exp_result,
  input  logic [4:0]             exp_flags,
  input  logic [1:0]             exp_fmt,
  input  logic                   exp_nanrelax,
  input  logic                   exp_last,
  input  logic                   dut_ready,
  input  logic [63:0]            dut_result,
  input  logic [4:0]             dut_flags,
  output logic                   mismatch,
  output logic [63:0]            result_diff,
  output logic [4:0]             flags_diff,
  output logic [15:0]            err_count,
  output logic [31:0]            pass_count,
  output logic [$clog2(DEPTH):0] level,
  output logic                   done,
  output logic                   fail,
  output logic                   overflow,
  output logic                   underflow
);

  logic              full, empty, push, pop, miss;
  logic [EntryW-1:0] rdata;
  fp_sb_entry_type   wr_entry, rd_entry;
  logic [63:0]       res_diff;
  logic [4:0]        flg_diff;

  logic        mismatch_q, mismatch_d;
  logic [63:0] result_diff_q, result_diff_d;
  logic [4:0]  flags_diff_q, flags_diff_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] pass_count_q, pass_count_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  assign exp_ready = !full && !done_q;
  assign push      = exp_valid && exp_ready;
  assign pop       = dut_ready && !empty && !done_q;

  assign wr_entry = '{result: exp_result, flags: exp_flags, fmt: exp_fmt,
                      nanrelax: exp_nanrelax, last: exp_last};
  assign rd_entry = fp_sb_entry_type'(rdata);

  fp_sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign res_diff = fp_result_diff(rd_entry, dut_result);
  assign flg_diff = dut_flags ^ rd_entry.flags;
  assign miss     = (|res_diff) || (|flg_diff);

  always_comb begin
    mismatch_d    = 1'b0;
    result_diff_d = result_diff_q;
    flags_diff_d  = flags_diff_q;
    err_count_d   = err_count_q;
    pass_count_d  = pass_count_q;
    done_d        = done_q;
    fail_d        = fail_q;
    overflow_d    = overflow_q || (exp_valid && full);
    underflow_d   = underflow_q || (dut_ready && empty);
    if (pop) begin
      result_diff_d = res_diff;
      flags_diff_d  = flg_diff;
      mismatch_d    = miss;
      if (miss) begin
        fail_d = 1'b1;
        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        if (STOP_ON_FAIL != 0) done_d = 1'b1;
      end else if (pass_count_q != 32'hFFFF_FFFF) begin
        pass_count_d = pass_count_q + 32'd1;
      end
      if (rd_entry.last) done_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mismatch_q    <= 1'b0;
      result_diff_q <= '0;
      flags_diff_q  <= '0;
      err_count_q   <= '0;
      pass_count_q  <= '0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      mismatch_q    <= mismatch_d;
      result_diff_q <= result_diff_d;
      flags_diff_q  <= flags_diff_d;
      err_count_q   <= err_count_d;
      pass_count_q  <= pass_count_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign mismatch    = mismatch_q;
  assign result_diff = result_diff_q;
  assign flags_diff  = flags_diff_q;
  assign err_count   = err_count_q;
  assign pass_count  = pass_count_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: doc/fp_scoreboard.md
FP_SCOREBOARD -- requirements
Module: fp_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning expected-entry FIFO depth (power of two, 2..64).
REQ-002 SHALL have parameter STOP_ON_FAIL, default 1, meaning freeze on first mismatch.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset==0 clears state immediately).
REQ-005 SHALL have ports exp_valid in 1 / exp_ready out 1, meaning expected-entry push handshake.
REQ-006 SHALL have ports exp_result in 64, exp_flags in 5, exp_fmt in 2, exp_nanrelax in 1, exp_last in 1, meaning the expected entry fields.
REQ-007 SHALL have ports dut_ready in 1, dut_result in 64, dut_flags in 5, meaning the FPU completion.
REQ-008 SHALL have outputs mismatch 1, result_diff 64, flags_diff 5, meaning registered compare outcome.
REQ-009 SHALL have outputs err_count 16, pass_count 32, level $clog2(DEPTH)+1, meaning counters and occupancy.
REQ-010 SHALL have outputs done 1, fail 1, overflow 1, underflow 1, meaning sticky status flags.

Function
REQ-011 SHALL drive exp_ready = !full && !done; push occurs when exp_valid && exp_ready.
REQ-012 SHALL set overflow when exp_valid && full, dropping the entry.
REQ-013 SHALL pop the oldest entry when dut_ready && !empty && !done.
REQ-014 SHALL set underflow on dut_ready && empty, with no compare and no counter change; no same-cycle push bypass.
REQ-015 SHALL accept push and pop in the same cycle when neither full nor empty blocks it, leaving level unchanged; when full, pop proceeds and push is refused.
REQ-016 SHALL, when exp_fmt==0 && exp_nanrelax && dut_result[31:0]==32'h7FC00000, compute the diff as {32'h0,1'b0,dut_result[30:22]^exp_result[30:22],22'h0}.
REQ-017 SHALL, when exp_fmt!=0 && exp_nanrelax && dut_result==64'h7FF8000000000000, compute the diff as {1'b0,dut_result[62:51]^exp_result[62:51],51'h0}.
REQ-018 SHALL otherwise compute result_diff = dut_result ^ exp_result; flags_diff = dut_flags ^ exp_flags always.
REQ-019 SHALL register the diffs and pulse mismatch for one cycle, exactly one cycle after the pop, iff either diff is nonzero; diffs hold their value otherwise.
REQ-020 SHALL increment err_count on mismatch, saturating at 16'hFFFF, and pass_count on a clean compare, saturating at all-ones.
REQ-021 SHALL set fail sticky with the mismatch pulse.
REQ-022 SHALL set done sticky in the cycle after popping an entry with exp_last==1, or with the first mismatch when STOP_ON_FAIL==1.
REQ-023 SHALL, after done, freeze counters and level and ignore pushes and pops; overflow/underflow are still recorded.
REQ-024 SHALL wrap read/write pointers modulo DEPTH, with full/empty derived from an extra pointer MSB.

Reset
REQ-025 SHALL, on reset==0, clear pointers, level, counters, diffs, mismatch, done, fail, overflow and underflow to 0; exp_ready reads 1 after release.
REQ-026 SHALL discard in-flight entries and a pending compare when reset asserts mid-operation, with no mismatch pulse after release.

Structure
REQ-027 SHALL define fp_sb_entry_type (result, flags, fmt, nanrelax, last) and the canonical-NaN constants in package fp_wire.
REQ-028 SHALL instantiate one sub-module, fp_sb_fifo (parametrised storage plus pointers, full/empty/level); compare logic and status live in the top module.

Verification
REQ-029 SHALL verify: push 3 entries (3F800000, 40000000, 40400000, flags 0, last on third), three dut_ready matching -> pass_count=3, err_count=0, done=1, fail=0.
REQ-030 SHALL verify: exp 7FC00001 fmt 0 nanrelax 1, dut 7FC00000 -> result_diff=0, no mismatch; same with nanrelax 0 -> result_diff=00000001, mismatch pulse.
REQ-031 SHALL verify: exp flags 5'h01, dut flags 5'h10 -> flags_diff=5'h11, fail=1, done=1 (STOP_ON_FAIL=1), later pops ignored.
REQ-032 SHALL verify: DEPTH=8, 9 pushes with no pops -> exp_ready low after 8, overflow=1, level=8; then push+pop in the same cycle -> level=7.
REQ-033 SHALL verify: dut_ready with empty FIFO -> underflow=1, counts unchanged; reset asserted between push and pop -> level=0, no mismatch after release.
